laser_cover_counter: RTL and testbench
======================================

// Module: laser_cover_counter
// PURPOSE
// - Coverage-scoring stage for the two-circle laser placement engine; sits downstream of the 40-point input buffer.
// - For one candidate centre (cx,cy), scans all stored points and counts those inside the radius-4 circle.
// - Optionally excludes points already covered by the other circle (ox,oy), giving the marginal gain of the candidate.
// - The centre-search controller issues one start per candidate and consumes cnt on cnt_valid.
// PARAMETERS
// - NUM_PTS    40  number of stored points scanned per request
// - RADIUS_SQ  16  squared radius; a point is inside when dx*dx+dy*dy <= RADIUS_SQ
// - CW         4   coordinate width (grid 0..15)
// PORTS
// - CLK        in   1  clock, rising edge
// - RST        in   1  reset, asynchronous, active-high
// - start      in   1  request a scan; sampled only in IDLE
// - cx, cy     in   CW candidate centre; latched on accepted start
// - ox, oy     in   CW other-circle centre; latched on accepted start
// - excl_en    in   1  1 = do not count points inside the other circle; latched on accepted start
// - rd_addr    out  6  point-buffer read address
// - pt_x, pt_y in   CW point at rd_addr; combinational (same-cycle) read
// - busy       out  1  high in SCAN and REPORT
// - cnt_valid  out  1  one-cycle pulse: cnt holds a new result
// - cnt        out  6  covered-point count, 0..NUM_PTS; holds until the next result
// BEHAVIOUR
// - Reset values: rd_addr=0, busy=0, cnt_valid=0, cnt=0, state=IDLE, accumulator=0.
// - RST is asynchronous: any phase aborts to IDLE with all outputs at reset values; the partial count is discarded.
// - FSM states: IDLE, SCAN, REPORT.
// - IDLE -> SCAN when start=1.
//   - Latch cx, cy, ox, oy, excl_en.
//   - Clear the accumulator; rd_addr=0.
// - SCAN lasts exactly NUM_PTS cycles, one point per cycle, rd_addr = 0..NUM_PTS-1.
//   - Each cycle: acc <= acc + hit.
//   - Increment rd_addr each cycle; on the cycle with rd_addr==NUM_PTS-1, go to REPORT.
//   - On that same edge, register cnt <= acc + hit and cnt_valid <= 1.
// - REPORT: one cycle with cnt_valid=1 and busy=1; then go to IDLE; cnt_valid returns to 0.
// - Hit rule:
//   - hit = in(cx,cy) & ~(excl_en & in(ox,oy)).
//   - in(a,b): dx=|pt_x-a| and dy=|pt_y-b|, computed as CW-bit unsigned magnitudes (no wrap).
//   - Squares are 8 bits; the sum is 9 bits; compare sum <= RADIUS_SQ.
// - Latency: start sampled in cycle t; SCAN occupies cycles t+1..t+NUM_PTS; cnt_valid=1 in cycle t+NUM_PTS+1.
// - Throughput: start is ignored in SCAN and REPORT (no queuing); one result per NUM_PTS+2 cycles maximum.
// - rd_addr holds 0 in IDLE and REPORT.
// - Latched inputs are stable for the whole scan; input changes during busy have no effect.
// - The accumulator is 6 bits and cannot overflow (max NUM_PTS=40).
// STRUCTURE
// - Shared package laser_pkg:
//   - NUM_PTS, RADIUS_SQ, CW constants.
//   - FSM state encoding (2-bit).
//   - Address width localparam ($clog2(NUM_PTS)).
// - One sub-module, laser_in_circle: combinational (px,py,ccx,ccy) -> inside.
//   - Instantiate twice: candidate and other circle.
// - Top module: FSM, address counter, accumulator, output registers.
// TESTING
// - Timing: all points (8,8), cand (8,8), excl_en=0 -> cnt=40; cnt_valid exactly 41 cycles after the start-sample cycle, 1 cycle wide.
// - Edge of circle: cand (8,8), far points (0,0) elsewhere.
//   - Points (12,8)x3 -> counted (sum 16).
//   - Points (12,9)x4 -> not counted (sum 17).
//   - Points (10,10)x2 -> counted (sum 8).
//   - Expected cnt=5.
// - No wrap: cand (0,0), points (15,15)x20 and (4,0)x20 -> cnt=20; |0-15| must not wrap.
// - Exclusion: cand (4,4), other (6,4), points (4,4)x10, (1,4)x5, (15,15)x25.
//   - excl_en=1 -> cnt=5.
//   - excl_en=0 -> cnt=15.
// - Busy handling: pulse start again at rd_addr=20.
//   - Ignored; rd_addr continues 21..39; a single cnt_valid.
//   - start held high continuously -> cnt_valid every 42 cycles.
// - Reset mid-scan: assert RST at rd_addr=20 -> busy, cnt_valid, cnt, rd_addr go to 0 before the next edge.
//   - A following start rescans from addr 0 with the correct count.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared constants and FSM encoding for the laser placement coverage stage.
package laser_pkg;

    localparam int NUM_PTS   = 40;
    localparam int RADIUS_SQ = 16;
    localparam int CW        = 4;
    localparam int ADDR_W    = $clog2(NUM_PTS);
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/laser_in_circle.sv
// Combinational point-in-circle test against the fixed radius.
// Distances are unsigned magnitudes, so a far point can never wrap back inside.
module laser_in_circle
    import laser_pkg::*;
(
    input  logic [CW-1:0] px_i,
    input  logic [CW-1:0] py_i,
    input  logic [CW-1:0] ccx_i,
    input  logic [CW-1:0] ccy_i,
    output logic          inside_o
);

    logic [CW-1:0]   dx;
    logic [CW-1:0]   dy;
    logic [2*CW-1:0] sq_x;
    logic [2*CW-1:0] sq_y;
    logic [2*CW:0]   sum;

    // Absolute differences, squares, and the squared-distance comparison.
    always_comb begin
        dx       = (px_i >= ccx_i) ? (px_i - ccx_i) : (ccx_i - px_i);
        dy       = (py_i >= ccy_i) ? (py_i - ccy_i) : (ccy_i - py_i);
        sq_x     = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
        sq_y     = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
        sum      = {1'b0, sq_x} + {1'b0, sq_y};
        inside_o = (sum <= (2*CW+1)'(RADIUS_SQ));
    end

endmodule

// File: rtl/laser_cover_counter.sv
// Scores one candidate centre: scans every stored point once and counts the
// points inside the candidate circle, optionally skipping points the other
// circle already covers.
module laser_cover_counter
    import laser_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [CW-1:0]     cx,
    input  logic [CW-1:0]     cy,
    input  logic [CW-1:0]     ox,
    input  logic [CW-1:0]     oy,
    input  logic              excl_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CW-1:0]     pt_x,
    input  logic [CW-1:0]     pt_y,
    output logic              busy,
    output logic              cnt_valid,
    output logic [CNT_W-1:0]  cnt
);

    state_e             state_q,     state_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [CNT_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               cnt_valid_q, cnt_valid_d;
    logic [CW-1:0]      cx_q, cy_q, ox_q, oy_q;
    logic [CW-1:0]      cx_d, cy_d, ox_d, oy_d;
    logic               excl_q,      excl_d;

    logic in_cand;
    logic in_other;
    logic hit;

    laser_in_circle u_cand (
        .px_i     (pt_x),
        .py_i     (pt_y),
        .ccx_i    (cx_q),
        .ccy_i    (cy_q),
        .inside_o (in_cand)
    );

    laser_in_circle u_other (
        .px_i     (pt_x),
        .py_i     (pt_y),
        .ccx_i    (ox_q),
        .ccy_i    (oy_q),
        .inside_o (in_other)
    );

    assign hit = in_cand & ~(excl_q & in_other);

    // Next-state logic: FSM transitions, address walk, accumulation and result capture.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cnt_valid_d = 1'b0;
        cx_d        = cx_q;
        cy_d        = cy_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        excl_d      = excl_q;

        unique case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (start) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    ox_d    = ox;
                    oy_d    = oy;
                    excl_d  = excl_en;
                    acc_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                acc_d = acc_q + {{(CNT_W-1){1'b0}}, hit};
                if (addr_q == ADDR_W'(NUM_PTS - 1)) begin
                    addr_d      = '0;
                    cnt_d       = acc_q + {{(CNT_W-1){1'b0}}, hit};
                    cnt_valid_d = 1'b1;
                    state_d     = ST_REPORT;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any scan and drops the partial count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            cnt_valid_q <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            excl_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values computed above.
            state_q     <= state_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cnt_valid_q <= cnt_valid_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            excl_q      <= excl_d;
        end
    end

    assign rd_addr   = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign cnt_valid = cnt_valid_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_laser_cover_counter.sv
// Self-checking bench for laser_cover_counter: directed spec scenarios plus
// randomized scans compared against a direct geometric count of the point buffer.
module tb_laser_cover_counter;
    import laser_pkg::*;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [CW-1:0]     cx, cy, ox, oy;
    logic              excl_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [CW-1:0]     pt_x, pt_y;
    logic              busy;
    logic              cnt_valid;
    logic [CNT_W-1:0]  cnt;

    int nvec  = 0;
    int nfail = 0;

    logic [CW-1:0] mem_x [NUM_PTS];
    logic [CW-1:0] mem_y [NUM_PTS];

    laser_cover_counter dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .cx        (cx),
        .cy        (cy),
        .ox        (ox),
        .oy        (oy),
        .excl_en   (excl_en),
        .rd_addr   (rd_addr),
        .pt_x      (pt_x),
        .pt_y      (pt_y),
        .busy      (busy),
        .cnt_valid (cnt_valid),
        .cnt       (cnt)
    );

    always #5 CLK = ~CLK;

    // Point buffer: combinational read at rd_addr.
    always_comb begin
        pt_x = '0;
        pt_y = '0;
        if (int'(rd_addr) < NUM_PTS) begin
            pt_x = mem_x[rd_addr];
            pt_y = mem_y[rd_addr];
        end
    end

    function automatic bit covers(int px, int py, int ax, int ay);
        int dx, dy;
        dx = px - ax;
        dy = py - ay;
        return (dx * dx + dy * dy) <= RADIUS_SQ;
    endfunction

    function automatic int model_count(int acx, int acy, int aox, int aoy, bit aex);
        int n;
        n = 0;
        for (int i = 0; i < NUM_PTS; i++) begin
            if (covers(int'(mem_x[i]), int'(mem_y[i]), acx, acy) &&
                !(aex && covers(int'(mem_x[i]), int'(mem_y[i]), aox, aoy)))
                n++;
        end
        return n;
    endfunction

    task automatic fill(input int x, input int y);
        for (int i = 0; i < NUM_PTS; i++) begin
            mem_x[i] = CW'(x);
            mem_y[i] = CW'(y);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_PTS; i++) begin
            mem_x[i] = CW'($urandom_range(15, 0));
            mem_y[i] = CW'($urandom_range(15, 0));
        end
    endtask

    task automatic set_req(input int acx, input int acy, input int aox, input int aoy, input bit aex);
        cx      = CW'(acx);
        cy      = CW'(acy);
        ox      = CW'(aox);
        oy      = CW'(aoy);
        excl_en = aex;
    endtask

    // Issue one start and observe the scan until cnt_valid (bounded).
    // lat = number of cycles after the start-sample cycle where cnt_valid is seen.
    task automatic do_scan(input int acx, input int acy, input int aox, input int aoy, input bit aex,
                           output int cnt_obs, output int lat, output int addr_errs);
        @(negedge CLK);
        set_req(acx, acy, aox, aoy, aex);
        start = 1'b1;
        @(negedge CLK);
        start     = 1'b0;
        lat       = -1;
        cnt_obs   = -1;
        addr_errs = 0;
        for (int k = 1; k <= 60; k++) begin
            if (cnt_valid) begin
                lat     = k;
                cnt_obs = int'(cnt);
                break;
            end
            if (k <= NUM_PTS && (int'(rd_addr) != k - 1 || !busy))
                addr_errs++;
            @(negedge CLK);
        end
    endtask

    // Advance until rd_addr reaches the target during a scan; -1 if never.
    task automatic wait_addr(input int target, output int found);
        found = -1;
        for (int k = 0; k < 60; k++) begin
            if (busy && int'(rd_addr) == target) begin
                found = target;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST     = 1'b1;
        start   = 1'b0;
        set_req(0, 0, 0, 0, 1'b0);
        fill(0, 0);
        repeat (3) @(negedge CLK);
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %0b want 0", busy); end
        nvec++; if (cnt_valid !== 1'b0) begin nfail++; $display("FAIL reset_cnt_valid got %0b want 0", cnt_valid); end
        nvec++; if (cnt !== '0) begin nfail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        nvec++; if (rd_addr !== '0) begin nfail++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_timing();
        int c, lat, ae;
        fill(8, 8);
        do_scan(8, 8, 0, 0, 1'b0, c, lat, ae);
        nvec++; if (c != 40) begin nfail++; $display("FAIL timing_cnt got %0d want 40", c); end
        nvec++; if (lat != NUM_PTS + 1) begin nfail++; $display("FAIL timing_latency got %0d want %0d", lat, NUM_PTS + 1); end
        nvec++; if (ae != 0) begin nfail++; $display("FAIL timing_addr_walk got %0d bad cycles want 0", ae); end
        nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL report_busy got %0b want 1", busy); end
        nvec++; if (rd_addr !== '0) begin nfail++; $display("FAIL report_rd_addr got %0d want 0", rd_addr); end
        @(negedge CLK);
        nvec++; if (cnt_valid !== 1'b0) begin nfail++; $display("FAIL pulse_width got %0b want 0", cnt_valid); end
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL after_report_busy got %0b want 0", busy); end
        nvec++; if (cnt !== 6'd40) begin nfail++; $display("FAIL cnt_hold got %0d want 40", cnt); end
    endtask

    task automatic test_edge();
        int c, lat, ae;
        fill(0, 0);
        for (int i = 0; i < 3; i++) begin mem_x[i] = 4'd12; mem_y[i] = 4'd8; end
        for (int i = 3; i < 7; i++) begin mem_x[i] = 4'd12; mem_y[i] = 4'd9; end
        for (int i = 20; i < 22; i++) begin mem_x[i] = 4'd10; mem_y[i] = 4'd10; end
        do_scan(8, 8, 0, 0, 1'b0, c, lat, ae);
        nvec++; if (c != 5) begin nfail++; $display("FAIL edge_cnt got %0d want 5", c); end
        nvec++; if (lat != NUM_PTS + 1) begin nfail++; $display("FAIL edge_latency got %0d want %0d", lat, NUM_PTS + 1); end
    endtask

    task automatic test_no_wrap();
        int c, lat, ae;
        for (int i = 0; i < NUM_PTS; i++) begin
            if (i % 2 == 0) begin mem_x[i] = 4'd15; mem_y[i] = 4'd15; end
            else            begin mem_x[i] = 4'd4;  mem_y[i] = 4'd0;  end
        end
        do_scan(0, 0, 0, 0, 1'b0, c, lat, ae);
        nvec++; if (c != 20) begin nfail++; $display("FAIL no_wrap_cnt got %0d want 20", c); end
    endtask

    task automatic test_exclusion();
        int c, lat, ae;
        fill(15, 15);
        for (int i = 0; i < 10; i++) begin mem_x[i] = 4'd4; mem_y[i] = 4'd4; end
        for (int i = 10; i < 15; i++) begin mem_x[i] = 4'd1; mem_y[i] = 4'd4; end
        do_scan(4, 4, 6, 4, 1'b1, c, lat, ae);
        nvec++; if (c != 5) begin nfail++; $display("FAIL excl_on_cnt got %0d want 5", c); end
        do_scan(4, 4, 6, 4, 1'b0, c, lat, ae);
        nvec++; if (c != 15) begin nfail++; $display("FAIL excl_off_cnt got %0d want 15", c); end
    endtask

    task automatic test_busy_ignore();
        int exp, found, pulses, got;
        fill_random();
        exp = model_count(7, 6, 9, 6, 1'b1);
        @(negedge CLK);
        set_req(7, 6, 9, 6, 1'b1);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_addr(20, found);
        nvec++; if (found != 20) begin nfail++; $display("FAIL busy_reach_addr got %0d want 20", found); end
        start = 1'b1;
        set_req(2, 13, 0, 0, 1'b0);
        @(negedge CLK);
        start = 1'b0;
        nvec++; if (int'(rd_addr) != 21) begin nfail++; $display("FAIL busy_addr_continue got %0d want 21", rd_addr); end
        pulses = 0;
        got    = -1;
        for (int k = 0; k < 60; k++) begin
            if (cnt_valid) begin pulses++; got = int'(cnt); end
            @(negedge CLK);
        end
        nvec++; if (pulses != 1) begin nfail++; $display("FAIL busy_pulses got %0d want 1", pulses); end
        nvec++; if (got != exp) begin nfail++; $display("FAIL busy_cnt got %0d want %0d", got, exp); end
    endtask

    task automatic test_start_held();
        int hits [$];
        fill(8, 8);
        @(negedge CLK);
        set_req(8, 8, 0, 0, 1'b0);
        start = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            @(negedge CLK);
            if (cnt_valid) hits.push_back(k);
        end
        start = 1'b0;
        nvec++; if (hits.size() != 3) begin nfail++; $display("FAIL held_pulse_count got %0d want 3", hits.size()); end
        for (int i = 0; i < hits.size() && i < 3; i++) begin
            nvec++;
            if (hits[i] != NUM_PTS + 1 + i * (NUM_PTS + 2)) begin
                nfail++;
                $display("FAIL held_pulse_%0d got cycle %0d want %0d", i, hits[i], NUM_PTS + 1 + i * (NUM_PTS + 2));
            end
        end
        repeat (50) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int found, c, lat, ae, exp;
        fill_random();
        @(negedge CLK);
        set_req(5, 10, 0, 0, 1'b0);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_addr(20, found);
        nvec++; if (found != 20) begin nfail++; $display("FAIL rst_reach_addr got %0d want 20", found); end
        RST = 1'b1;
        #1;
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
        nvec++; if (cnt_valid !== 1'b0) begin nfail++; $display("FAIL rst_mid_cnt_valid got %0b want 0", cnt_valid); end
        nvec++; if (cnt !== '0) begin nfail++; $display("FAIL rst_mid_cnt got %0d want 0", cnt); end
        nvec++; if (rd_addr !== '0) begin nfail++; $display("FAIL rst_mid_rd_addr got %0d want 0", rd_addr); end
        @(negedge CLK);
        RST = 1'b0;
        exp = model_count(5, 10, 0, 0, 1'b0);
        do_scan(5, 10, 0, 0, 1'b0, c, lat, ae);
        nvec++; if (c != exp) begin nfail++; $display("FAIL rst_rescan_cnt got %0d want %0d", c, exp); end
        nvec++; if (ae != 0) begin nfail++; $display("FAIL rst_rescan_addr got %0d bad cycles want 0", ae); end
    endtask

    task automatic test_random();
        int c, lat, ae, exp, acx, acy, aox, aoy;
        bit aex;
        for (int n = 0; n < 24; n++) begin
            fill_random();
            acx = $urandom_range(15, 0);
            acy = $urandom_range(15, 0);
            aox = $urandom_range(15, 0);
            aoy = $urandom_range(15, 0);
            aex = 1'($urandom_range(1, 0));
            exp = model_count(acx, acy, aox, aoy, aex);
            do_scan(acx, acy, aox, aoy, aex, c, lat, ae);
            nvec++;
            if (c != exp) begin
                nfail++;
                $display("FAIL random_%0d_cnt got %0d want %0d (c=%0d,%0d o=%0d,%0d ex=%0b)",
                         n, c, exp, acx, acy, aox, aoy, aex);
            end
            nvec++; if (lat != NUM_PTS + 1) begin nfail++; $display("FAIL random_%0d_latency got %0d want %0d", n, lat, NUM_PTS + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_edge();
        test_no_wrap();
        test_exclusion();
        test_busy_ignore();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
